// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the immediate encoder.
// Split-encoding enumerators exist only when IMM_ENC_SPLIT_EN is defined.
package imm_enc_pkg;

  localparam int unsigned IMM_W       = 12;
  localparam int unsigned RC_W        = 5;
  localparam int unsigned LONG_W      = 17;
  localparam int unsigned SPLIT_SHIFT = 15;

`ifdef IMM_ENC_SPLIT_EN
  typedef enum logic [1:0] {
    FmtShort   = 2'd0,
    FmtLong    = 2'd1,
    FmtSplitHi = 2'd2,
    FmtSplitLo = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StOutOne = 2'd1,
    StOutHi  = 2'd2,
    StOutLo  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    FmtShort = 2'd0,
    FmtLong  = 2'd1,
    FmtErr   = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StOutOne = 2'd1
  } state_e;
`endif

  // Format of the first beat produced for a value with the given range flags.
  function automatic fmt_e classify(input logic fits12, input logic fits17);
    if (fits12) return FmtShort;
    if (fits17) return FmtLong;
`ifdef IMM_ENC_SPLIT_EN
    return FmtSplitHi;
`else
    return FmtErr;
`endif
  endfunction

endpackage

// File: rtl/imm_range_chk_mod.sv
// Signed range classification of a 32-bit constant: fits in 12 bits, fits in 17 bits.
module imm_range_chk_mod
  import imm_enc_pkg::*;
(
  input  logic [31:0] value_i,
  output logic        fits12_o,
  output logic        fits17_o
);

  // A value fits N signed bits when bits [31:N-1] are all copies of the sign.
  logic [31-IMM_W+1:0]  upper12;
  logic [31-LONG_W+1:0] upper17;

  assign upper12  = value_i[31:IMM_W-1];
  assign upper17  = value_i[31:LONG_W-1];
  assign fits12_o = (&upper12) | ~(|upper12);
  assign fits17_o = (&upper17) | ~(|upper17);

endmodule

// File: rtl/imm_encoder_mod.sv
// Encodes a 32-bit constant into Imm/Rc beats (SHORT, LONG, or SPLIT_HI+SPLIT_LO).
// Define IMM_ENC_SPLIT_EN to enable split encoding; otherwise out-of-range values yield ERR.
module imm_encoder_mod
  import imm_enc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [31:0]       data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [RC_W-1:0]   rc_o,
  output logic              ext_ctrl_o,
  output logic [1:0]        fmt_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

`ifdef IMM_ENC_SPLIT_EN
  localparam int unsigned DataW = 32;
`else
  // Without splitting, only the 17-bit forms ever read the stored word.
  localparam int unsigned DataW = LONG_W;
`endif

  state_e           state_q, state_d;
  fmt_e             fmt_q, fmt_d;
  logic [DataW-1:0] data_q;
  logic             fits12, fits17;
  logic             in_xfer, out_xfer;

  imm_range_chk_mod u_range_chk (
    .value_i  (data_i),
    .fits12_o (fits12),
    .fits17_o (fits17)
  );

  assign fmt_d    = classify(fits12, fits17);
  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= '0;
      fmt_q  <= FmtShort;
    end else if (in_xfer) begin
      data_q <= data_i[DataW-1:0];
      fmt_q  <= fmt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
`ifdef IMM_ENC_SPLIT_EN
          state_d = (fmt_d == FmtSplitHi) ? StOutHi : StOutOne;
`else
          state_d = StOutOne;
`endif
        end
      end
      StOutOne: if (out_xfer) state_d = StIdle;
`ifdef IMM_ENC_SPLIT_EN
      StOutHi:  if (out_xfer) state_d = StOutLo;
      StOutLo:  if (out_xfer) state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decode only registered state, so they are stable across a stall.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    imm_o       = '0;
    rc_o        = '0;
    ext_ctrl_o  = 1'b0;
    fmt_o       = FmtShort;
    unique case (state_q)
      StIdle: in_ready_o = 1'b1;
      StOutOne: begin
        out_valid_o = 1'b1;
        fmt_o       = fmt_q;
        if (fmt_q == FmtShort) begin
          imm_o = data_q[IMM_W-1:0];
        end else if (fmt_q == FmtLong) begin
          ext_ctrl_o = 1'b1;
          imm_o      = data_q[LONG_W-1:RC_W];
          rc_o       = data_q[RC_W-1:0];
        end
      end
`ifdef IMM_ENC_SPLIT_EN
      StOutHi: begin
        out_valid_o = 1'b1;
        ext_ctrl_o  = 1'b1;
        fmt_o       = FmtSplitHi;
        imm_o       = data_q[31 -: IMM_W];
        rc_o        = data_q[SPLIT_SHIFT+RC_W-1:SPLIT_SHIFT];
      end
      StOutLo: begin
        out_valid_o = 1'b1;
        ext_ctrl_o  = 1'b1;
        fmt_o       = FmtSplitLo;
        imm_o       = {2'b00, data_q[SPLIT_SHIFT-1:RC_W]};
        rc_o        = data_q[RC_W-1:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/imm_encoder_mod.md
IMM_ENCODER_MOD -- requirements
Module: imm_encoder_mod

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 rstn_i  input  1  asynchronous active-low reset.
REQ-004 data_i  input  32  constant to encode.
REQ-005 in_valid_i  input  1  data_i is valid.
REQ-006 in_ready_o  output  1  block accepts data_i this cycle.
REQ-007 imm_o  output  12  Immediate field.
REQ-008 rc_o  output  5  Rc field.
REQ-009 ext_ctrl_o  output  1  0 = 12-bit form; 1 = {Imm,Rc} 17-bit form.
REQ-010 fmt_o  output  2  beat tag: SHORT, LONG, SPLIT_HI, SPLIT_LO (or ERR when the split feature is not compiled in).
REQ-011 out_valid_o  output  1  output beat valid.
REQ-012 out_ready_i  input  1  consumer takes the beat.

Function
REQ-013 Input transfer SHALL occur when in_valid_i and in_ready_o are both 1; output transfer when out_valid_o and out_ready_i are both 1.
REQ-014 FSM states SHALL be IDLE, OUT_ONE, OUT_HI and OUT_LO; in_ready_o SHALL be 1 only in IDLE.
REQ-015 On an input transfer the word SHALL be registered; out_valid_o SHALL rise the following cycle (latency 1).
REQ-016 Fits 12-bit signed (-2048..2047): the block SHALL go to OUT_ONE with fmt SHORT, ext_ctrl 0, imm = data[11:0], rc = 0.
REQ-017 Otherwise, fits 17-bit signed (-65536..65535): the block SHALL go to OUT_ONE with fmt LONG, ext_ctrl 1, imm = data[16:5], rc = data[4:0].
REQ-018 Otherwise: the block SHALL go to OUT_HI with fmt SPLIT_HI, ext_ctrl 1, {imm,rc} = data[31:15]; after that transfer, go to OUT_LO with fmt SPLIT_LO, ext_ctrl 1, imm = {2'b00, data[14:5]}, rc = data[4:0].
REQ-019 A split value SHALL satisfy value = (sign_ext17(HI) << 15) | LO[14:0].
REQ-020 On a transfer in OUT_ONE or OUT_LO, the FSM SHALL return to IDLE; in_ready_o SHALL rise the next cycle (no same-cycle accept).
REQ-021 While out_valid_o=1 and out_ready_i=0, imm_o, rc_o, ext_ctrl_o and fmt_o SHALL hold stable.
REQ-022 out_ready_i while out_valid_o=0 SHALL be ignored; in_valid_i outside IDLE SHALL be ignored.
REQ-023 Boundary values SHALL be classified as follows: 2047 SHORT, 2048 LONG, -2049 LONG, 65535 LONG, 65536 SPLIT, -65537 SPLIT, 0x8000_0000 SPLIT.

Reset
REQ-024 While rstn_i=0, the FSM SHALL be IDLE; out_valid_o, imm_o, rc_o, ext_ctrl_o and fmt_o SHALL be 0; in_ready_o SHALL be 1.
REQ-025 Reset asserted mid-split SHALL discard the pending LO beat; no beat SHALL appear after release without a new input.

Configuration
REQ-026 Macro IMM_ENC_SPLIT_EN: when defined, split encoding SHALL operate per REQ-018.
REQ-027 When IMM_ENC_SPLIT_EN is undefined, an out-of-17-bit-range value SHALL produce one beat with fmt ERR, imm 0, rc 0, ext_ctrl 0, and OUT_HI and OUT_LO SHALL not be compiled in.

Structure
REQ-028 Package imm_enc_pkg SHALL hold the fmt_e and state_e typedefs and the constants IMM_W=12, RC_W=5, LONG_W=17, SPLIT_SHIFT=15.
REQ-029 One combinational sub-module, imm_range_chk_mod, SHALL compute fits12 and fits17 from a 32-bit value.

Verification
REQ-030 Encode 0x0000_07FF -> one beat: SHORT, imm 0x7FF, rc 0x00, ext_ctrl 0, out_valid_o one cycle after accept.
REQ-031 Encode 0xFFFF_F800 -> SHORT, imm 0x800; encode 0x0000_0800 -> LONG, imm 0x040, rc 0x00, ext_ctrl 1.
REQ-032 Encode 0x1234_5678 (split enabled) -> SPLIT_HI imm 0x123, rc 0x08; then SPLIT_LO imm 0x2B3, rc 0x18; reconstruction equals input.
REQ-033 Hold out_ready_i=0 for 3 cycles on a LONG beat -> outputs stable, in_ready_o=0 throughout; transfer on cycle 4 -> in_ready_o=1 on the next cycle.
REQ-034 Assert rstn_i during SPLIT_HI stall -> all outputs 0 immediately; after release, no SPLIT_LO beat appears.
REQ-035 Build without IMM_ENC_SPLIT_EN, encode 0x0001_0000 -> single ERR beat, imm 0, rc 0.
